// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_pkg
// Brief    : Shared fetch-stage state encoding, constants and counter helper.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   localparam int          c_COUNT_WIDTH       = 32;
   localparam logic [31:0] c_DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   function automatic logic [c_COUNT_WIDTH-1:0] sat_inc(input logic [c_COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + c_COUNT_WIDTH'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : ROM, redirect and decode-side handshake bundle of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12
);
   logic [ADDRESS_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0]    rom_data;
   logic                     redirect_valid;
   logic [ADDRESS_WIDTH-1:0] redirect_pc;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    out_instr;
   logic [ADDRESS_WIDTH-1:0] out_pc;
   logic                     halted;
   logic [31:0]              fetch_count;

   modport master (
      output rom_addr, out_valid, out_instr, out_pc, halted, fetch_count,
      input  rom_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  rom_addr, out_valid, out_instr, out_pc, halted, fetch_count,
      output rom_data, redirect_valid, redirect_pc, out_ready
   );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : PC owner and ROM front end; hands (instr, pc) pairs to decode.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                     DATA_WIDTH    = 32,
   parameter int                     ADDRESS_WIDTH = 12,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [DATA_WIDTH-1:0]  HALT_WORD     = c_DEFAULT_HALT_WORD
) (
   input logic                 clk,
   input logic                 rst_n,
   instruction_fetch_if.master bus
);

   fetch_state_t               r_state;
   logic [ADDRESS_WIDTH-1:0]   r_pc;
   logic                       r_out_valid;
   logic [DATA_WIDTH-1:0]      r_out_instr;
   logic [ADDRESS_WIDTH-1:0]   r_out_pc;
   logic                       r_halted;
   logic [c_COUNT_WIDTH-1:0]   r_fetch_count;

   logic                       w_slot_free;
   logic                       w_is_halt;

   assign w_slot_free = !r_out_valid || bus.out_ready;
   assign w_is_halt   = (bus.rom_data == HALT_WORD);

   // rom_data reflects Mem[r_pc] at each rising edge, so capture pairs it with r_pc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_BOOT;
         r_pc          <= RESET_PC;
         r_out_valid   <= 1'b0;
         r_out_instr   <= '0;
         r_out_pc      <= '0;
         r_halted      <= 1'b0;
         r_fetch_count <= '0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               r_state <= ST_RUN;
               if (bus.redirect_valid)
                  r_pc <= bus.redirect_pc;
            end
            ST_RUN: begin
               if (bus.redirect_valid) begin
                  r_pc        <= bus.redirect_pc;
                  r_out_valid <= 1'b0;
               end else if (w_slot_free) begin
                  r_out_instr   <= bus.rom_data;
                  r_out_pc      <= r_pc;
                  r_out_valid   <= 1'b1;
                  r_pc          <= r_pc + ADDRESS_WIDTH'(1);
                  r_fetch_count <= sat_inc(r_fetch_count);
                  if (w_is_halt) begin
                     r_state  <= ST_HALT;
                     r_halted <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
               if (bus.redirect_valid) begin
                  r_state     <= ST_RUN;
                  r_pc        <= bus.redirect_pc;
                  r_halted    <= 1'b0;
                  r_out_valid <= 1'b0;
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_BOOT;
            end
         endcase
      end
   end

   assign bus.rom_addr    = r_pc;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_instr   = r_out_instr;
   assign bus.out_pc      = r_out_pc;
   assign bus.halted      = r_halted;
   assign bus.fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Directed boundary checks plus randomized scoreboard run of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

   localparam int          c_DW   = 32;
   localparam int          c_AW   = 12;
   localparam logic [31:0] c_HALT = 32'hFFFF_FFFF;

   typedef struct {
      logic [c_AW-1:0] pc;
      logic [c_DW-1:0] instr;
   } exp_t;

   logic clk;
   logic rst_n;

   instruction_fetch_if #(.DATA_WIDTH(c_DW), .ADDRESS_WIDTH(c_AW)) bus ();

   instruction_fetch #(
      .DATA_WIDTH   (c_DW),
      .ADDRESS_WIDTH(c_AW),
      .RESET_PC     (12'd0),
      .HALT_WORD    (c_HALT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [c_DW-1:0] mem [0:(1<<c_AW)-1];
   exp_t            exp_q[$];
   logic [c_AW-1:0] model_pc;
   bit              stream_done;
   bit              sb_en;
   int              n_tests;
   int              n_fail;
   int              n_xfer;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: data for the presented address is ready at the next rising edge.
   always @(negedge clk) bus.rom_data <= mem[bus.rom_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected program-order stream: sequential words up to and including a halt word.
   task automatic topup();
      while (!stream_done && exp_q.size() < 16) begin
         exp_q.push_back('{pc: model_pc, instr: mem[model_pc]});
         if (mem[model_pc] == c_HALT) stream_done = 1'b1;
         model_pc = model_pc + 1'b1;
      end
   endtask

   task automatic refill(input logic [c_AW-1:0] target);
      exp_q.delete();
      model_pc    = target;
      stream_done = 1'b0;
      topup();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the expected stream on every handshake.
   logic        prev_hold;
   logic        prev_redir;
   logic [63:0] prev_snap;
   always begin
      @(negedge clk);
      #2;
      if (sb_en && rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL xfer_unexpected: got pc %0h expected no transfer", bus.out_pc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("xfer_pc", 64'(bus.out_pc), 64'(e.pc));
               chk("xfer_instr", 64'(bus.out_instr), 64'(e.instr));
               n_xfer++;
            end
         end
         if (prev_hold && !prev_redir)
            chk("hold_stable", {19'd0, bus.out_valid, bus.out_pc, bus.out_instr}, prev_snap);
         prev_hold  = bus.out_valid && !bus.out_ready;
         prev_redir = bus.redirect_valid;
         prev_snap  = {19'd0, bus.out_valid, bus.out_pc, bus.out_instr};
      end else begin
         prev_hold  = 1'b0;
         prev_redir = 1'b0;
         prev_snap  = '0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit              redir_pend;
      logic [c_AW-1:0] redir_tgt;
      n_tests = 0; n_fail = 0; n_xfer = 0; sb_en = 1'b0;
      redir_pend = 1'b0; redir_tgt = '0;
      rst_n = 1'b0;
      bus.out_ready      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      for (int i = 0; i < (1 << c_AW); i++) mem[i] = 32'(i + 100);
      mem[10] = c_HALT;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_addr", 64'(bus.rom_addr), 64'd0);
      chk("rst_count", 64'(bus.fetch_count), 64'd0);
      chk("rst_halted", 64'(bus.halted), 64'd0);
      chk("rst_out", {20'd0, bus.out_pc, bus.out_instr}, 64'd0);

      @(negedge clk) rst_n = 1'b1;
      step();
      chk("boot_valid", 64'(bus.out_valid), 64'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("boot_seq", {19'd0, bus.out_valid, bus.out_pc, bus.out_instr},
             {19'd0, 1'b1, 12'(k), 32'(k + 100)});
      end
      chk("boot_count", 64'(bus.fetch_count), 64'd3);

      repeat (3) step();
      chk("bp_start_pc", 64'(bus.out_pc), 64'd5);
      bus.out_ready = 1'b0;
      repeat (3) begin
         step();
         chk("bp_hold", {bus.out_valid, bus.out_pc, bus.out_instr, bus.rom_addr},
             {1'b1, 12'd5, 32'd105, 12'd6});
         chk("bp_count", 64'(bus.fetch_count), 64'd6);
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp_release", 64'(bus.out_pc), 64'd6);
      step();
      chk("pre_redir_pc", 64'(bus.out_pc), 64'd7);

      bus.redirect_valid = 1'b1; bus.redirect_pc = 12'd40;
      step();
      bus.redirect_valid = 1'b0;
      chk("redir_bubble", {bus.out_valid, bus.rom_addr}, {1'b0, 12'd40});
      step();
      chk("redir_target", {bus.out_valid, bus.out_pc, bus.out_instr}, {1'b1, 12'd40, 32'd140});

      bus.redirect_valid = 1'b1; bus.redirect_pc = 12'd8;
      step();
      bus.redirect_valid = 1'b0;
      repeat (3) step();
      chk("halt_word", {bus.out_valid, bus.out_pc, bus.out_instr, bus.halted},
          {1'b1, 12'd10, c_HALT, 1'b1});
      step();
      chk("halt_drain", {bus.out_valid, bus.halted, bus.rom_addr}, {1'b0, 1'b1, 12'd11});
      repeat (20) begin
         step();
         chk("halt_frozen", {bus.out_valid, bus.rom_addr}, {1'b0, 12'd11});
      end
      bus.redirect_valid = 1'b1; bus.redirect_pc = 12'd0;
      step();
      bus.redirect_valid = 1'b0;
      chk("halt_exit", {bus.out_valid, bus.halted, bus.rom_addr}, {1'b0, 1'b0, 12'd0});
      step();
      chk("halt_resume", {bus.out_valid, bus.out_pc, bus.out_instr}, {1'b1, 12'd0, 32'd100});

      bus.redirect_valid = 1'b1; bus.redirect_pc = 12'hFFF;
      step();
      bus.redirect_valid = 1'b0;
      step();
      chk("wrap_top", {bus.out_pc, bus.out_instr}, {12'hFFF, 32'(4095 + 100)});
      step();
      chk("wrap_zero", {bus.out_pc, bus.out_instr}, {12'h000, 32'd100});

      force dut.r_fetch_count = 32'hFFFF_FFFE;
      #1;
      release dut.r_fetch_count;
      step();
      chk("sat_reach", 64'(bus.fetch_count), 64'hFFFF_FFFF);
      step();
      chk("sat_hold", 64'(bus.fetch_count), 64'hFFFF_FFFF);

      chk("areset_pre_valid", 64'(bus.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("areset", {bus.out_valid, bus.halted, bus.rom_addr}, {1'b0, 1'b0, 12'd0});
      chk("areset_count", 64'(bus.fetch_count), 64'd0);

      // Randomized phase against the program-order stream model.
      for (int i = 0; i < (1 << c_AW); i++)
         mem[i] = ($urandom_range(0, 29) == 0) ? c_HALT : $urandom;
      refill(12'd0);
      sb_en = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (redir_pend) refill(redir_tgt);
         topup();
         #1;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 11) == 0) begin
            redir_tgt = ($urandom_range(0, 3) == 0) ? 12'(12'hFF0 + $urandom_range(0, 15))
                                                    : 12'($urandom);
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_tgt;
            redir_pend         = 1'b1;
         end else begin
            bus.redirect_valid = 1'b0;
            redir_pend         = 1'b0;
         end
      end
      @(negedge clk);
      if (redir_pend) refill(redir_tgt);
      #1;
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      sb_en = 1'b0;
      chk("xfer_progress", 64'(n_xfer > 200), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly upstream of the instruction ROM. It owns the program counter, drives the ROM address, and captures the returned instruction word together with its PC. It presents the pair to decode through a valid/ready handshake. It supports branch/jump redirect with flush, a HALT instruction, and a fetched-instruction counter.

## Interface
- DATA_WIDTH, 32, instruction word width (matches ROM).
- ADDRESS_WIDTH, 12, PC/ROM address width; PC is word-addressed.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rom_addr  output  ADDRESS_WIDTH  ROM address; equals internal PC register.
- rom_data  input  DATA_WIDTH  ROM read data. The ROM registers it on the falling edge, so it holds Mem[rom_addr] at the next rising edge.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDRESS_WIDTH  target PC.
- out_valid  output  1  out_instr/out_pc hold a valid instruction.
- out_ready  input  1  decode accepts; transfer when out_valid && out_ready.
- out_instr  output  DATA_WIDTH  fetched instruction.
- out_pc  output  ADDRESS_WIDTH  address of out_instr.
- halted  output  1  high while in HALT state.
- fetch_count  output  32  number of instructions captured since reset; saturates at 32'hFFFF_FFFF.

## Operation
- States: BOOT, RUN, HALT.
- Reset (async assert) sets:
  - state=BOOT, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0.
- BOOT: lasts exactly one cycle after reset release. No capture, because rom_data is not yet guaranteed to hold Mem[RESET_PC]. Next state is RUN.
- Define slot_free = !out_valid || out_ready.
- RUN, redirect_valid=1 (priority over everything):
  - pc<=redirect_pc, out_valid<=0.
  - No capture; the in-flight rom_data is discarded.
  - A transfer already asserted this cycle still completes (decode owns it).
- RUN, no redirect, slot_free=1:
  - out_instr<=rom_data, out_pc<=pc, out_valid<=1, pc<=pc+1, fetch_count+=1 (saturating).
  - If rom_data==HALT_WORD: the word is still output, then state<=HALT and halted<=1.
- RUN, no redirect, slot_free=0: stall. pc, outputs and count hold; the ROM keeps re-reading the same address.
- HALT:
  - pc frozen at the halt address+1; no captures.
  - out_valid drops after the pending word transfers.
  - redirect_valid moves to RUN with pc<=redirect_pc and halted<=0.
- PC arithmetic is modulo 2^ADDRESS_WIDTH: pc=all-ones increments to 0 with no flag.
- Redirect during BOOT is accepted: pc<=redirect_pc, and BOOT still lasts its one cycle.

## Timing
- rom_addr is a direct register output, with no combinational path from inputs.
- Capture latency is zero bubbles: the word for pc is sampled on the rising edge that ends the cycle in which pc was presented. Sustained throughput is 1 instr/cycle with out_ready held high.
- Redirect cost: the redirect edge itself produces no capture, so out_valid=0 for one cycle. The target instruction appears on out_* one cycle after the redirect edge.
- The first valid output appears 2 rising edges after reset release: BOOT, then capture.
- Reset asserted mid-operation clears everything immediately, with no need to wait for an edge. Pending outputs are lost.
- out_* are stable while out_valid && !out_ready.

## Structure
- Shared processor package/header: state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and the default HALT_WORD constant.
- Single flat module. No sub-module is needed; the saturating counter is inline.

## Test plan
- Reset/boot: ROM holds Mem[i]=i+100, out_ready=1, release reset.
  - Cycle 1: out_valid=0.
  - Then out_pc=0/out_instr=100, 1/101, 2/102 on consecutive cycles.
  - fetch_count=3.
- Backpressure: hold out_ready=0 for 3 cycles while out_pc=5. out_pc=5/out_instr=105 stay stable, rom_addr=6 holds, fetch_count does not increase. Release: out_pc=6 on the next cycle.
- Redirect: assert redirect_valid with redirect_pc=40 while out_pc=7.
  - Next cycle: out_valid=0, rom_addr=40.
  - Following cycle: out_pc=40, out_instr=140.
- Halt: Mem[10]=HALT_WORD.
  - out_pc=10 is output with the halt word; then halted=1 and out_valid=0 after the transfer.
  - rom_addr stays 11 for 20 cycles.
  - Redirect to 0 resumes with out_pc=0.
- Wrap and saturation:
  - Redirect to 12'hFFF: outputs out_pc=FFF, then 000.
  - Force fetch_count to all-ones via a long run or bench preload: it stays 32'hFFFF_FFFF.
- Async reset mid-stream: drop rst_n between edges while out_valid=1. out_valid, halted and fetch_count go to 0 immediately, rom_addr goes to RESET_PC.
